mem_bus_arbiter: RTL and testbench

Arbitrates the single 16-bit memory bus between the uop execute stage (data requests) and the instruction fetch unit. Data requests have priority, with a starvation guard for fetch. The block registers the bus command and returns read data. It drives `stop` back to the execute stage while a data access is outstanding, and it aborts bus cycles that exceed a wait-state limit.

---
 rtl/mem_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_bus_arbiter
//  Brief    : Arbitrates the 16-bit memory bus between execute-stage data
//             requests and instruction fetch. Data wins, with a starvation
//             guard for fetch and a wait-state timeout abort.
//  Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int MAX_WAIT     = 15,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        a_rst,
    input  logic        ex_rq,
    input  logic        ex_cmd,
    input  logic        ex_width,
    input  logic [15:0] ex_addr,
    input  logic [15:0] ex_wdata,
    input  logic        if_rq,
    input  logic [15:0] if_addr,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        bus_req,
    output logic        bus_we,
    output logic        bus_byte,
    output logic [15:0] bus_addr,
    output logic [15:0] bus_wdata,
    output logic [15:0] ex_rdata,
    output logic        ex_done,
    output logic [15:0] if_data,
    output logic        if_valid,
    output logic        bus_err,
    output logic        stop
);

    // Last wait count before the abort edge: the abort happens on the edge
    // where the count would reach MAX_WAIT, giving MAX_WAIT bus cycles total.
    localparam logic [7:0] WAIT_LAST  = 8'(MAX_WAIT - 1);
    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_FETCH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  starve_q, starve_d;
    logic [7:0]  wait_q, wait_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        byte_q, byte_d;
    logic [15:0] ex_rdata_q, ex_rdata_d;
    logic [15:0] if_data_q, if_data_d;
    logic        ex_done_q, ex_done_d;
    logic        if_valid_q, if_valid_d;
    logic        bus_err_q, bus_err_d;

    logic        w_timeout;
    logic        w_fetch_forced;

    assign w_timeout      = (wait_q == WAIT_LAST);
    assign w_fetch_forced = if_rq && (starve_q == STARVE_MAX);

    // Next-state, grant, latching and completion logic
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        wait_d     = wait_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        byte_d     = byte_q;
        ex_rdata_d = ex_rdata_q;
        if_data_d  = if_data_q;
        ex_done_d  = 1'b0;
        if_valid_d = 1'b0;
        bus_err_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (ex_rq && !w_fetch_forced) begin
                    state_d = ST_DATA;
                    wait_d  = 8'd0;
                    addr_d  = ex_addr;
                    wdata_d = ex_wdata;
                    we_d    = ex_cmd;
                    byte_d  = ex_width;
                    // Count data grants that made fetch wait; saturate.
                    if (!if_rq) begin
                        starve_d = 4'd0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + 4'd1;
                    end
                end else if (if_rq) begin
                    state_d  = ST_FETCH;
                    wait_d   = 8'd0;
                    starve_d = 4'd0;
                    addr_d   = if_addr;
                    we_d     = 1'b0;
                    byte_d   = 1'b0;
                end
            end
            ST_DATA: begin
                if (bus_ack || w_timeout) begin
                    state_d   = ST_IDLE;
                    ex_done_d = 1'b1;
                    bus_err_d = !bus_ack;
                    if (!we_q) begin
                        if (!bus_ack) begin
                            ex_rdata_d = 16'hFFFF;
                        end else if (byte_q) begin
                            ex_rdata_d = {8'h00, bus_rdata[7:0]};
                        end else begin
                            ex_rdata_d = bus_rdata;
                        end
                    end
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            ST_FETCH: begin
                if (bus_ack || w_timeout) begin
                    state_d    = ST_IDLE;
                    if_valid_d = 1'b1;
                    bus_err_d  = !bus_ack;
                    if_data_d  = bus_ack ? bus_rdata : 16'hFFFF;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, asynchronously cleared
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state_q    <= ST_IDLE;
            starve_q   <= 4'd0;
            wait_q     <= 8'd0;
            addr_q     <= 16'h0000;
            wdata_q    <= 16'h0000;
            we_q       <= 1'b0;
            byte_q     <= 1'b0;
            ex_rdata_q <= 16'h0000;
            if_data_q  <= 16'h0000;
            ex_done_q  <= 1'b0;
            if_valid_q <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            wait_q     <= wait_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            byte_q     <= byte_d;
            ex_rdata_q <= ex_rdata_d;
            if_data_q  <= if_data_d;
            ex_done_q  <= ex_done_d;
            if_valid_q <= if_valid_d;
            bus_err_q  <= bus_err_d;
        end
    end

    assign bus_req   = (state_q != ST_IDLE);
    assign bus_we    = we_q;
    assign bus_byte  = byte_q;
    assign bus_addr  = addr_q;
    assign bus_wdata = wdata_q;
    assign ex_rdata  = ex_rdata_q;
    assign ex_done   = ex_done_q;
    assign if_data   = if_data_q;
    assign if_valid  = if_valid_q;
    assign bus_err   = bus_err_q;
    // Stall the execute stage until the done pulse is visible.
    assign stop      = ex_rq & ~ex_done_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_bus_arbiter
//  Brief    : Self-checking bench for mem_bus_arbiter: directed scenarios
//             plus randomized traffic against a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_bus_arbiter;

    localparam int MW = 15;
    localparam int SL = 3;

    logic        clk = 1'b0;
    logic        a_rst;
    logic        ex_rq, ex_cmd, ex_width;
    logic [15:0] ex_addr, ex_wdata;
    logic        if_rq;
    logic [15:0] if_addr;
    logic        bus_ack;
    logic [15:0] bus_rdata;
    logic        bus_req, bus_we, bus_byte;
    logic [15:0] bus_addr, bus_wdata, ex_rdata, if_data;
    logic        ex_done, if_valid, bus_err, stop;

    int errors = 0;
    int checks = 0;

    mem_bus_arbiter #(.MAX_WAIT(MW), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .a_rst(a_rst),
        .ex_rq(ex_rq), .ex_cmd(ex_cmd), .ex_width(ex_width),
        .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .if_rq(if_rq), .if_addr(if_addr),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .bus_req(bus_req), .bus_we(bus_we), .bus_byte(bus_byte),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .ex_rdata(ex_rdata), .ex_done(ex_done),
        .if_data(if_data), .if_valid(if_valid),
        .bus_err(bus_err), .stop(stop)
    );

    always #5 clk = ~clk;

    // ---------------- transaction-level reference model ----------------
    // owner: 0 = bus free, 1 = data transaction, 2 = fetch transaction
    int          m_owner, m_elapsed, m_starve;
    logic        m_we, m_byte, m_done, m_valid, m_err;
    logic [15:0] m_addr, m_wdata, m_rdata, m_ifdata;

    task automatic model_reset();
        m_owner = 0; m_elapsed = 0; m_starve = 0;
        m_we = 0; m_byte = 0; m_done = 0; m_valid = 0; m_err = 0;
        m_addr = 0; m_wdata = 0; m_rdata = 0; m_ifdata = 0;
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        if (a_rst) begin
            model_reset();
            return;
        end
        m_done = 0; m_valid = 0; m_err = 0;
        if (m_owner == 0) begin
            if (ex_rq && !(if_rq && m_starve == SL)) begin
                m_owner = 1; m_elapsed = 0;
                m_addr = ex_addr; m_wdata = ex_wdata; m_we = ex_cmd; m_byte = ex_width;
                m_starve = if_rq ? ((m_starve + 1 > SL) ? SL : m_starve + 1) : 0;
            end else if (if_rq) begin
                m_owner = 2; m_elapsed = 0; m_starve = 0;
                m_addr = if_addr; m_we = 0; m_byte = 0;
            end
        end else if (bus_ack || m_elapsed + 1 == MW) begin
            m_err = !bus_ack;
            if (m_owner == 1) begin
                m_done = 1;
                if (!m_we)
                    m_rdata = !bus_ack ? 16'hFFFF : (m_byte ? (bus_rdata & 16'h00FF) : bus_rdata);
            end else begin
                m_valid = 1;
                m_ifdata = bus_ack ? bus_rdata : 16'hFFFF;
            end
            m_owner = 0;
        end else begin
            m_elapsed++;
        end
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model (called once per cycle).
    task automatic compare();
        #1;
        chk("bus_req",   {15'd0, bus_req},  {15'd0, m_owner != 0});
        chk("bus_we",    {15'd0, bus_we},   {15'd0, m_we});
        chk("bus_byte",  {15'd0, bus_byte}, {15'd0, m_byte});
        chk("bus_addr",  bus_addr,  m_addr);
        chk("bus_wdata", bus_wdata, m_wdata);
        chk("ex_rdata",  ex_rdata,  m_rdata);
        chk("ex_done",   {15'd0, ex_done},  {15'd0, m_done});
        chk("if_data",   if_data,   m_ifdata);
        chk("if_valid",  {15'd0, if_valid}, {15'd0, m_valid});
        chk("bus_err",   {15'd0, bus_err},  {15'd0, m_err});
        chk("stop",      {15'd0, stop},     {15'd0, ex_rq & ~m_done});
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
    endtask

    int          c;
    logic [15:0] grants[$];
    logic        prev_req, back_to_back;
    int          pct;

    initial begin
        a_rst = 1; ex_rq = 0; ex_cmd = 0; ex_width = 0; ex_addr = 0; ex_wdata = 0;
        if_rq = 0; if_addr = 0; bus_ack = 0; bus_rdata = 0;
        model_reset();
        @(negedge clk);
        compare();
        chk("rst_bus_req", {15'd0, bus_req}, 16'd0);
        chk("rst_ex_rdata", ex_rdata, 16'h0000);
        step();
        a_rst = 0;
        compare();
        step();

        // ---- single word read, ack on 3rd bus cycle ----
        ex_rq = 1; ex_cmd = 0; ex_width = 0; ex_addr = 16'h1234; bus_ack = 0;
        compare();
        step();
        c = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_done) ex_rq = 0;
            bus_ack = (c == 2); bus_rdata = 16'hBEEF;
            compare();
            if (!bus_req) break;
            c++;
            step();
        end
        chk("rd_req_cycles", 16'(c), 16'd3);
        chk("rd_done", {15'd0, ex_done}, 16'd1);
        chk("rd_rdata", ex_rdata, 16'hBEEF);
        chk("rd_stop_low", {15'd0, stop}, 16'd0);
        bus_ack = 0;
        step();
        compare();

        // ---- byte write ----
        ex_rq = 1; ex_cmd = 1; ex_width = 1; ex_addr = 16'h0010; ex_wdata = 16'h00A5;
        compare();
        step();
        compare();
        chk("bw_we", {15'd0, bus_we}, 16'd1);
        chk("bw_byte", {15'd0, bus_byte}, 16'd1);
        chk("bw_wdata", bus_wdata, 16'h00A5);
        bus_ack = 1; bus_rdata = 16'h9999;
        step();
        ex_rq = 0; bus_ack = 0;
        compare();
        chk("bw_done", {15'd0, ex_done}, 16'd1);
        chk("bw_rdata_kept", ex_rdata, 16'hBEEF);
        step();

        // ---- both requesting continuously, immediate ack ----
        ex_rq = 1; ex_cmd = 0; ex_width = 0; ex_addr = 16'hAAAA;
        if_rq = 1; if_addr = 16'h5555; bus_ack = 1; bus_rdata = 16'h1111;
        prev_req = 0; back_to_back = 0;
        for (int i = 0; i < 10; i++) begin
            compare();
            if (bus_req) grants.push_back(bus_addr);
            if (bus_req && prev_req) back_to_back = 1;
            prev_req = bus_req;
            step();
        end
        chk("grant_count", 16'(grants.size()), 16'd5);
        if (grants.size() == 5) begin
            chk("grant0", grants[0], 16'hAAAA);
            chk("grant1", grants[1], 16'hAAAA);
            chk("grant2", grants[2], 16'hAAAA);
            chk("grant3", grants[3], 16'h5555);
            chk("grant4", grants[4], 16'hAAAA);
        end
        chk("idle_between", {15'd0, back_to_back}, 16'd0);
        ex_rq = 0; if_rq = 0; bus_ack = 0;
        compare();
        step();
        compare();
        step();

        // ---- timeout on a read ----
        ex_rq = 1; ex_cmd = 0; ex_width = 0; ex_addr = 16'h0042; bus_ack = 0;
        compare();
        step();
        c = 0;
        for (int i = 0; i < 40; i++) begin
            compare();
            if (!bus_req) break;
            c++;
            step();
        end
        chk("to_req_cycles", 16'(c), 16'(MW));
        chk("to_done", {15'd0, ex_done}, 16'd1);
        chk("to_err", {15'd0, bus_err}, 16'd1);
        chk("to_rdata", ex_rdata, 16'hFFFF);
        ex_rq = 0;
        step();

        // ---- reset during a fetch ----
        if_rq = 1; if_addr = 16'h0777;
        compare();
        step();
        compare();
        step();
        compare();
        #1;
        a_rst = 1;
        model_reset();
        compare();
        chk("rst_mid_req", {15'd0, bus_req}, 16'd0);
        chk("rst_mid_addr", bus_addr, 16'h0000);
        chk("rst_mid_rdata", ex_rdata, 16'h0000);
        step();
        a_rst = 0;
        compare();
        step();
        bus_ack = 1; bus_rdata = 16'hCAFE;
        compare();
        step();
        if_rq = 0; bus_ack = 0;
        compare();
        chk("rst_refetch_valid", {15'd0, if_valid}, 16'd1);
        chk("rst_refetch_data", if_data, 16'hCAFE);
        step();

        // ---- randomized traffic ----
        for (int i = 0; i < 4000; i++) begin
            case ((i / 500) % 4)
                0: pct = 50;
                1: pct = 20;
                2: pct = 0;
                default: pct = 90;
            endcase
            if (a_rst) a_rst = 0;
            else if ($urandom_range(0, 199) == 0) begin
                a_rst = 1;
                model_reset();
            end
            if (ex_rq && (m_done || $urandom_range(0, 99) < 2)) ex_rq = 0;
            else if (!ex_rq && $urandom_range(0, 99) < 30) begin
                ex_rq = 1;
                ex_cmd = 1'($urandom_range(0, 1));
                ex_width = 1'($urandom_range(0, 1));
                ex_addr = 16'($urandom);
                ex_wdata = 16'($urandom);
            end
            if (if_rq && m_valid) if_rq = 0;
            else if (!if_rq && $urandom_range(0, 99) < 30) begin
                if_rq = 1;
                if_addr = 16'($urandom);
            end
            bus_ack = ($urandom_range(0, 99) < pct);
            bus_rdata = 16'($urandom);
            compare();
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
